// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Package     : riscv_pkg
// Description : Shared definitions for the ID/EX pipeline boundary: datapath
//               width, forwarding-risk codes carried with each instruction,
//               and the operand forwarding select encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // Default datapath width
    localparam int XLEN = 32;

    // Forwarding risk of the instruction producing a result.
    // Codes other than NONE and LOAD behave as ALU results.
    localparam logic [2:0] FWD_RISK_NONE = 3'b000;
    localparam logic [2:0] FWD_RISK_ALU  = 3'b001;
    localparam logic [2:0] FWD_RISK_LOAD = 3'b010;

    // Operand source select produced by the forwarding unit
    typedef enum logic [1:0] {
        SEL_REG = 2'b00,   // register file data captured in ID
        SEL_MEM = 2'b01,   // result currently in MEM
        SEL_WB  = 2'b10,   // result currently in WB
        SEL_RET = 2'b11    // most recently retired WB result
    } fwd_sel_e;

    // A producer only forces an interlock when its result is a load
    function automatic logic is_load_risk(input logic [2:0] risk);
        return (risk == FWD_RISK_LOAD);
    endfunction

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/operand_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module      : operand_fwd_mux
// Description : Four-way operand source mux for one EX operand. Selects the
//               registered operand, the live MEM or WB result, or the
//               retired-result latch.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fwd_mux
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  fwd_sel_e        sel,
    input  logic [XLEN-1:0] reg_data,
    input  logic [XLEN-1:0] mem_result,
    input  logic [XLEN-1:0] wb_result,
    input  logic [XLEN-1:0] retired,
    output logic [XLEN-1:0] operand
);

    // Pick the operand source named by the registered select
    always_comb begin
        operand = reg_data;
        case (sel)
            SEL_REG: operand = reg_data;
            SEL_MEM: operand = mem_result;
            SEL_WB:  operand = wb_result;
            default: operand = retired;
        endcase
    end

endmodule : operand_fwd_mux
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with operand forwarding. Holds the
//               instruction in EX, resolves its operands from register data,
//               MEM/WB results or a retired-result latch, raises the load-use
//               interlock, and freezes resolved operands while stalled.
// Config macro: FWD_STATS_EN - adds saturating fwd_count / hold_count outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_imm,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [4:0]      id_rd,
    input  logic [2:0]      id_fwd_risk,
    input  logic [1:0]      FwdA,
    input  logic [1:0]      FwdB,
    input  logic [XLEN-1:0] mem_result,
    input  logic [XLEN-1:0] wb_result,
    input  logic            wb_we,
    output logic            id_hold,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] ex_op_a,
    output logic [XLEN-1:0] ex_op_b,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_fwd_risk
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]     fwd_count,
    output logic [31:0]     hold_count
`endif
);

    // Stall tracking: RUN means the next stall cycle is the first one and
    // must capture the resolved operands; STALLED means they are captured.
    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_STALLED = 1'b1;

    logic [0:0]      state;
    logic [0:0]      state_next;
    logic            stall_capture;

    // EX operand registers and their forwarding selects
    logic [XLEN-1:0] ex_rs1_data;
    logic [XLEN-1:0] ex_rs2_data;
    fwd_sel_e        sel_a;
    fwd_sel_e        sel_b;

    // Last result written back by WB
    logic [XLEN-1:0] retired;

    // Load-use interlock: the instruction in ID wants the MEM result of a load
    // that is still in EX, so that data does not exist yet.
    assign id_hold = id_valid & ex_valid & is_load_risk(ex_fwd_risk) &
                     ((FwdA == SEL_MEM) | (FwdB == SEL_MEM));

    // Operand resolution from the registered selects
    operand_fwd_mux #(
        .XLEN       (XLEN)
    ) u_fwd_a (
        .sel        (sel_a),
        .reg_data   (ex_rs1_data),
        .mem_result (mem_result),
        .wb_result  (wb_result),
        .retired    (retired),
        .operand    (ex_op_a)
    );

    operand_fwd_mux #(
        .XLEN       (XLEN)
    ) u_fwd_b (
        .sel        (sel_b),
        .reg_data   (ex_rs2_data),
        .mem_result (mem_result),
        .wb_result  (wb_result),
        .retired    (retired),
        .operand    (ex_op_b)
    );

    // Stall-tracking state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next stall state: flush dominates, otherwise follow the stall input
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = ST_RUN;
        end else if (stall) begin
            state_next = ST_STALLED;
        end else begin
            state_next = ST_RUN;
        end
    end

    // Capture the resolved operands only on the first cycle of a stall
    always_comb begin
        stall_capture = 1'b0;
        if ((state == ST_RUN) && stall && !flush) begin
            stall_capture = 1'b1;
        end
    end

    // EX pipeline registers: flush, then stall, then interlock, then load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_imm      <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_rd       <= '0;
            ex_fwd_risk <= FWD_RISK_NONE;
            sel_a       <= SEL_REG;
            sel_b       <= SEL_REG;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (stall) begin
            // Live MEM/WB values move on while EX waits, so pin the operands
            // into the data registers and read them back directly from now on.
            if (stall_capture) begin
                ex_rs1_data <= ex_op_a;
                ex_rs2_data <= ex_op_b;
                sel_a       <= SEL_REG;
                sel_b       <= SEL_REG;
            end
        end else if (id_hold) begin
            ex_valid    <= 1'b0;
            ex_fwd_risk <= FWD_RISK_NONE;
        end else begin
            ex_valid    <= id_valid;
            ex_pc       <= id_pc;
            ex_imm      <= id_imm;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_rd       <= id_rd;
            ex_fwd_risk <= id_fwd_risk;
            sel_a       <= fwd_sel_e'(FwdA);
            sel_b       <= fwd_sel_e'(FwdB);
        end
    end

    // Retired-result latch follows every WB write, independent of stall/flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= '0;
        end else if (wb_we) begin
            retired <= wb_result;
        end
    end

`ifdef FWD_STATS_EN
    logic normal_load;
    logic fwd_event;

    assign normal_load = !flush && !stall && !id_hold;
    assign fwd_event   = normal_load && id_valid &&
                         ((FwdA != SEL_REG) || (FwdB != SEL_REG));

    // Count forwarded instructions entering EX, saturating at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_count <= '0;
        end else if (fwd_event && (fwd_count != 32'hFFFF_FFFF)) begin
            fwd_count <= fwd_count + 32'd1;
        end
    end

    // Count interlock cycles, saturating at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_count <= '0;
        end else if (id_hold && (hold_count != 32'hFFFF_FFFF)) begin
            hold_count <= hold_count + 32'd1;
        end
    end
`endif

endmodule : id_ex_stage
`default_nettype wire
